adc_result_reader: RTL and testbench
====================================

ADC_RESULT_READER -- requirements
Module: adc_result_reader

Interface
REQ-001 Parameter MATRIX_BITS, default 12: width of the ADC result word.
REQ-002 Parameter FIFO_DEPTH, default 4: result buffer entries; power of two, 2..16.
REQ-003 clk  input  1  single block clock, the same clock as the ADC controller.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 conv_finished  input  1  conversion-done flag from the ADC controller; high for exactly one cycle per conversion.
REQ-006 result  input  MATRIX_BITS  conversion result; valid while conv_finished=1.
REQ-007 dout  output  MATRIX_BITS  head-of-buffer result (show-ahead).
REQ-008 dout_valid  output  1  buffer non-empty.
REQ-009 dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-011 overflow  output  1  sticky flag, set when a result was dropped.
REQ-012 ovf_clear  input  1  synchronous clear of overflow.

Function
REQ-013 Capture event = conv_finished=1 AND registered conv_finished (finished_q)=0, i.e. a rising edge only.
REQ-014 finished_q shall reset to 1, so the dummy result after reset (conv_finished held high, result=0) is never captured.
REQ-015 On a capture event with the buffer not full, result shall be written into the tail of the buffer on that clock edge; dout_valid rises the next cycle (latency 1).
REQ-016 Pop = dout_valid AND dout_ready; the head advances on that edge, and dout shows the next entry in the following cycle.
REQ-017 With the buffer full and a capture without a pop, the new result shall be dropped, contents unchanged, and overflow set on that edge.
REQ-018 A simultaneous capture and pop while full shall be accepted; level stays FIFO_DEPTH and overflow is not set.
REQ-019 A simultaneous capture and pop while empty shall not pop (dout_valid=0); the capture is stored and level becomes 1.
REQ-020 Read and write pointers shall wrap modulo FIFO_DEPTH; level = writes − pops, never exceeding FIFO_DEPTH.
REQ-021 dout shall hold a stable value while dout_valid=1 and dout_ready=0.
REQ-022 ovf_clear=1 shall clear overflow; if an overflow event occurs in the same cycle, set wins.
REQ-023 The block has no combinational path from conv_finished or result to any output.

Reset
REQ-024 While rst=0: level=0, dout_valid=0, dout=0, overflow=0, pointers=0, finished_q=1, tag counter=0.
REQ-025 A reset asserted mid-operation shall discard all buffered results immediately (asynchronous); no entry survives.

Configuration
REQ-026 With macro ADC_READOUT_TAG_EN defined, an output dout_tag [3:0] shall be added, carrying a per-capture sequence number that is stored with each entry.
REQ-027 With ADC_READOUT_TAG_EN, the tag counter shall increment on every capture event, including dropped ones, and wrap 15->0, so that consumers can detect gaps.
REQ-028 Without ADC_READOUT_TAG_EN, no dout_tag port and no tag storage shall exist; all other behaviour is identical.

Structure
REQ-029 Package adc_pkg shall hold the MATRIX_BITS default, the tag width constant (4), and the typedef of the result word.
REQ-030 Buffer storage and pointers shall be the sub-module adc_result_fifo (push, pop, full, empty, level).
REQ-031 Edge detection, overflow handling and tag logic shall stay in adc_result_reader.

Verification
REQ-032 Reset, then hold conv_finished=1 for 3 cycles, then 0 -> no capture, dout_valid=0, level=0.
REQ-033 Three pulses with result=0x123, 0x7FF, 0xFFF and dout_ready=1 -> dout sequence 0x123, 0x7FF, 0xFFF, each valid 1 cycle after its pulse.
REQ-034 dout_ready=0 and 5 pulses (0x001..0x005) -> level=4, overflow=1, dout=0x001; then drain -> 0x001..0x004.
REQ-035 Full buffer, pulse 0x0AA coinciding with a pop -> overflow stays 0, 0x0AA is the last read.
REQ-036 rst pulsed low with level=3 -> level=0, dout_valid=0 asynchronously; the next pulse 0x055 is read first.
REQ-037 ADC_READOUT_TAG_EN, 18 pulses with 2 dropped -> tags read 0..15,0,1 minus the dropped values, showing the gap.

Source files
------------

// File: rtl/adc_pkg.sv
// ----------------------------------------------------------------------------
// adc_pkg
// Shared constants and types for the ADC result readout path.
//   ADC_MATRIX_BITS : default width of one ADC conversion result
//   ADC_TAG_BITS    : width of the per-capture sequence tag (used only when
//                     ADC_READOUT_TAG_EN is defined)
//   adc_result_t    : result word at the default width
// ----------------------------------------------------------------------------
package adc_pkg;

    localparam int unsigned ADC_MATRIX_BITS = 12;
    localparam int unsigned ADC_TAG_BITS    = 4;

    typedef logic [ADC_MATRIX_BITS-1:0] adc_result_t;

endpackage

// File: rtl/adc_result_fifo.sv
// ----------------------------------------------------------------------------
// adc_result_fifo
// Show-ahead buffer for captured ADC results.
//   clk    : block clock
//   rst    : asynchronous active-low reset; empties the buffer immediately
//   push   : write din at the tail (ignored when full unless popping too)
//   din    : entry to store
//   pop    : advance the head (ignored when empty)
//   dout   : head entry, zero while empty
//   full   : DEPTH entries held
//   empty  : no entries held
//   level  : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ----------------------------------------------------------------------------
module adc_result_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign level = count;

    // A push into a full buffer is legal when the head leaves on the same edge:
    // the write lands in the slot being vacated.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_comb begin
        dout = '0;
        if (!empty) begin
            dout = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/adc_result_reader.sv
// ----------------------------------------------------------------------------
// adc_result_reader
// Captures one result per ADC conversion (rising edge of conv_finished),
// buffers it and presents it to a ready/valid consumer.
//   clk           : block clock, shared with the ADC controller
//   rst           : asynchronous active-low reset; discards buffered results
//   conv_finished : one-cycle conversion-done flag
//   result        : conversion result, valid while conv_finished=1
//   dout          : head-of-buffer result (show-ahead)
//   dout_valid    : buffer non-empty
//   dout_ready    : consumer takes dout this cycle
//   level         : buffer occupancy
//   overflow      : sticky, set when a result was dropped on a full buffer
//   ovf_clear     : synchronous clear of overflow (a same-cycle drop wins)
//   dout_tag      : per-capture sequence number of the head entry
//                   (present only with ADC_READOUT_TAG_EN defined)
// Optional feature macro: ADC_READOUT_TAG_EN
// ----------------------------------------------------------------------------
module adc_result_reader
    import adc_pkg::*;
#(
    parameter int unsigned MATRIX_BITS = ADC_MATRIX_BITS,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          conv_finished,
    input  logic [MATRIX_BITS-1:0]        result,
    output logic [MATRIX_BITS-1:0]        dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          ovf_clear
`ifdef ADC_READOUT_TAG_EN
    ,
    output logic [ADC_TAG_BITS-1:0]       dout_tag
`endif
);

`ifdef ADC_READOUT_TAG_EN
    localparam int unsigned ENTRY_W = MATRIX_BITS + ADC_TAG_BITS;
`else
    localparam int unsigned ENTRY_W = MATRIX_BITS;
`endif

    logic               finished_q;
    logic               capture;
    logic               pop_fire;
    logic               accept;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;

    // finished_q resets high so the controller's post-reset dummy result
    // (conv_finished held high) never looks like a rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            finished_q <= 1'b1;
        end else begin
            finished_q <= conv_finished;
        end
    end

    assign capture    = conv_finished & ~finished_q;
    assign dout_valid = ~fifo_empty;
    assign pop_fire   = dout_valid & dout_ready;
    assign accept     = capture & (~fifo_full | pop_fire);
    assign drop       = capture & fifo_full & ~pop_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

`ifdef ADC_READOUT_TAG_EN
    logic [ADC_TAG_BITS-1:0] tag_cnt;

    // Counts every capture, dropped ones included, so gaps stay visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_cnt <= '0;
        end else if (capture) begin
            tag_cnt <= tag_cnt + ADC_TAG_BITS'(1);
        end
    end

    assign push_data = {tag_cnt, result};
    assign dout      = head[MATRIX_BITS-1:0];
    assign dout_tag  = head[ENTRY_W-1 -: ADC_TAG_BITS];
`else
    assign push_data = result;
    assign dout      = head;
`endif

    adc_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (push_data),
        .pop   (pop_fire),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: tb/tb_adc_result_reader.sv
module tb_adc_result_reader;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        conv_finished;
    logic [11:0] result;
    logic [11:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  level;
    logic        overflow;
    logic        ovf_clear;
`ifdef ADC_READOUT_TAG_EN
    logic [3:0]  dout_tag;
`endif

    adc_result_reader #(
        .MATRIX_BITS (12),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .conv_finished (conv_finished),
        .result        (result),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .level         (level),
        .overflow      (overflow),
        .ovf_clear     (ovf_clear)
`ifdef ADC_READOUT_TAG_EN
        ,
        .dout_tag      (dout_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cf;
        logic [11:0] res;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [2:0]  el;
        logic [11:0] ed;
        logic        eo;
    } vec_t;

    typedef struct {
        logic [11:0] data;
        logic [3:0]  tag;
    } ent_t;

    vec_t        tbl[$];
    ent_t        sb[$];
    logic [3:0]  rd_tags[$];
    logic [3:0]  exp_tags[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        m_fq = 1'b1;
    logic        m_ovf = 1'b0;
    logic [3:0]  m_tag = 4'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic cf, input logic [11:0] res, input logic rdy, input logic clr,
                       input logic ev, input logic [2:0] el, input logic [11:0] ed, input logic eo);
        vec_t v;
        v.cf = cf; v.res = res; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.el = el; v.ed = ed; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        sb.delete();
        m_fq  = 1'b1;
        m_ovf = 1'b0;
        m_tag = 4'd0;
    endtask

    // Checks the present state against the scoreboard, advances the model
    // with the given inputs, then drives them across one clock edge.
    task automatic step(input logic cf, input logic [11:0] res, input logic rdy, input logic clr);
        logic pop_m;
        logic cap_m;
        logic drop_m;
        ent_t e;
        chk("sb_valid", 32'(dout_valid), 32'(sb.size() != 0));
        chk("sb_level", 32'(level), 32'(sb.size()));
        chk("sb_overflow", 32'(overflow), 32'(m_ovf));
        if (sb.size() != 0) begin
            chk("sb_dout", 32'(dout), 32'(sb[0].data));
`ifdef ADC_READOUT_TAG_EN
            chk("sb_tag", 32'(dout_tag), 32'(sb[0].tag));
            if (rdy) rd_tags.push_back(dout_tag);
`endif
        end
        pop_m  = rdy && (sb.size() != 0);
        cap_m  = cf && !m_fq;
        drop_m = 1'b0;
        if (pop_m) void'(sb.pop_front());
        if (cap_m) begin
            if (sb.size() < DEPTH) begin
                e.data = res;
                e.tag  = m_tag;
                sb.push_back(e);
            end else begin
                drop_m = 1'b1;
            end
            m_tag = m_tag + 4'd1;
        end
        if (drop_m) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_fq = cf;
        conv_finished = cf;
        result        = res;
        dout_ready    = rdy;
        ovf_clear     = clr;
        tick();
    endtask

    initial begin
        rst = 1'b0; conv_finished = 1'b1; result = '0; dout_ready = 1'b0; ovf_clear = 1'b0;
        repeat (2) tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        model_reset();

        // conv_finished held high out of reset: never captured
        add(1, 12'h000, 0, 0,  0, 0, 12'h000, 0);
        add(1, 12'h000, 0, 0,  0, 0, 12'h000, 0);
        add(1, 12'h000, 0, 0,  0, 0, 12'h000, 0);
        add(0, 12'h000, 0, 0,  0, 0, 12'h000, 0);
        // streaming with ready high; capture into empty buffer while ready
        add(1, 12'h123, 1, 0,  1, 1, 12'h123, 0);
        add(0, 12'h000, 1, 0,  0, 0, 12'h000, 0);
        add(1, 12'h7FF, 1, 0,  1, 1, 12'h7FF, 0);
        add(0, 12'h000, 1, 0,  0, 0, 12'h000, 0);
        add(1, 12'hFFF, 1, 0,  1, 1, 12'hFFF, 0);
        add(0, 12'h000, 1, 0,  0, 0, 12'h000, 0);
        // five pulses with no consumer: fifth is dropped
        add(1, 12'h001, 0, 0,  1, 1, 12'h001, 0);
        add(0, 12'h000, 0, 0,  1, 1, 12'h001, 0);
        add(1, 12'h002, 0, 0,  1, 2, 12'h001, 0);
        add(0, 12'h000, 0, 0,  1, 2, 12'h001, 0);
        add(1, 12'h003, 0, 0,  1, 3, 12'h001, 0);
        add(0, 12'h000, 0, 0,  1, 3, 12'h001, 0);
        add(1, 12'h004, 0, 0,  1, 4, 12'h001, 0);
        add(0, 12'h000, 0, 0,  1, 4, 12'h001, 0);
        add(1, 12'h005, 0, 0,  1, 4, 12'h001, 1);
        add(0, 12'h000, 0, 0,  1, 4, 12'h001, 1);
        // clear, then capture and pop together while full
        add(0, 12'h000, 0, 1,  1, 4, 12'h001, 0);
        add(1, 12'h0AA, 1, 0,  1, 4, 12'h002, 0);
        add(0, 12'h000, 1, 0,  1, 3, 12'h003, 0);
        add(0, 12'h000, 1, 0,  1, 2, 12'h004, 0);
        add(0, 12'h000, 1, 0,  1, 1, 12'h0AA, 0);
        add(0, 12'h000, 1, 0,  0, 0, 12'h000, 0);
        // refill, then drop in the same cycle as a clear: set wins
        add(1, 12'h011, 0, 0,  1, 1, 12'h011, 0);
        add(0, 12'h000, 0, 0,  1, 1, 12'h011, 0);
        add(1, 12'h022, 0, 0,  1, 2, 12'h011, 0);
        add(0, 12'h000, 0, 0,  1, 2, 12'h011, 0);
        add(1, 12'h033, 0, 0,  1, 3, 12'h011, 0);
        add(0, 12'h000, 0, 0,  1, 3, 12'h011, 0);
        add(1, 12'h044, 0, 0,  1, 4, 12'h011, 0);
        add(0, 12'h000, 0, 0,  1, 4, 12'h011, 0);
        add(1, 12'h055, 0, 1,  1, 4, 12'h011, 1);
        add(0, 12'h000, 0, 1,  1, 4, 12'h011, 0);
        add(0, 12'h000, 1, 0,  1, 3, 12'h022, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].cf, tbl[i].res, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("v%0d_valid", i), 32'(dout_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].el));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(tbl[i].eo));
            if (tbl[i].ev) chk($sformatf("v%0d_dout", i), 32'(dout), 32'(tbl[i].ed));
        end

        // asynchronous reset with three entries held, away from any edge
        rst = 1'b0;
        #2;
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_valid", 32'(dout_valid), 32'd0);
        chk("async_rst_dout", 32'(dout), 32'd0);
        model_reset();
        tick();
        rst = 1'b1;
        step(0, 12'h000, 0, 0);
        step(1, 12'h055, 0, 0);
        chk("post_rst_level", 32'(level), 32'd1);
        chk("post_rst_dout", 32'(dout), 32'h055);
        step(0, 12'h000, 1, 0);
        chk("post_rst_drained", 32'(dout_valid), 32'd0);

        // random traffic, alternating light and heavy consumer back-pressure
        for (int i = 0; i < 400; i++) begin
            int unsigned bias;
            bias = ((i / 50) % 2 == 0) ? 3 : 1;
            step($urandom_range(0, 1) == 1, 12'($urandom), $urandom_range(0, 3) < bias,
                 $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 6; i++) step(0, 12'h000, 1, 0);
        chk("random_drained", 32'(level), 32'd0);

`ifdef ADC_READOUT_TAG_EN
        rst = 1'b0;
        #2;
        model_reset();
        rd_tags.delete();
        tick();
        rst = 1'b1;
        step(0, 12'h000, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 12'(i + 1), 0, 0);
            step(0, 12'h000, 0, 0);
        end
        for (int i = 6; i < 18; i++) begin
            step(1, 12'(i + 1), 1, 0);
            step(0, 12'h000, 1, 0);
        end
        for (int i = 0; i < 6; i++) step(0, 12'h000, 1, 0);
        for (int t = 0; t < 18; t++) begin
            if (t != 4 && t != 5) exp_tags.push_back(4'(t));
        end
        chk("tag_read_count", 32'(rd_tags.size()), 32'(exp_tags.size()));
        for (int i = 0; i < exp_tags.size(); i++) begin
            if (i < rd_tags.size()) chk($sformatf("tag_seq%0d", i), 32'(rd_tags[i]), 32'(exp_tags[i]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
